// File: rtl/stage_mem.sv
// MIPS memory-access stage: issues loads/stores on a req/ack bus, stalls upstream
// while an access is outstanding and registers the write-back bundle.
module stage_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [1:0]  wbi,
  input  logic        M,
  input  logic [3:0]  regaddr,
  input  logic [31:0] data_b,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic [3:0]  wb_regaddr,
  output logic        bus_error
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_lat_q;
  logic [RW-1:0]   regaddr_lat_q;
  logic [DW-1:0]   alu_lat_q;
  logic            m_lat_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [DW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW-1:0]   wb_data_q;
  logic            wb_we_q;
  logic [RW-1:0]   wb_regaddr_q;
  logic            bus_error_q;

  logic access_c;
  logic last_c;

  assign access_c = M | wbi[1];
  assign last_c   = (cnt_q == CW'(TIMEOUT - 1));

  // Hold upstream while a request is being launched or is still outstanding.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (state_q == S_IDLE) stall = access_c;
      else                   stall = !mem_ack && !last_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      we_lat_q      <= 1'b0;
      regaddr_lat_q <= '0;
      alu_lat_q     <= '0;
      m_lat_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wb_data_q     <= '0;
      wb_we_q       <= 1'b0;
      wb_regaddr_q  <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access_c) begin
            we_lat_q      <= wbi[0];
            regaddr_lat_q <= regaddr;
            alu_lat_q     <= alu_out;
            m_lat_q       <= M;
            mem_req_q     <= 1'b1;
            mem_we_q      <= M;
            mem_addr_q    <= {alu_out[31:2], 2'b00};
            mem_wdata_q   <= data_b;
            wb_we_q       <= 1'b0;
            cnt_q         <= '0;
            state_q       <= S_WAIT;
          end else begin
            wb_data_q    <= alu_out;
            wb_we_q      <= wbi[0];
            wb_regaddr_q <= regaddr;
          end
        end
        S_WAIT: begin
          // An ack coinciding with the last allowed cycle still completes the op.
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            wb_data_q    <= m_lat_q ? alu_lat_q : mem_rdata;
            wb_we_q      <= we_lat_q;
            wb_regaddr_q <= regaddr_lat_q;
            state_q      <= S_IDLE;
          end else if (last_c) begin
            mem_req_q   <= 1'b0;
            wb_we_q     <= 1'b0;
            bus_error_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            wb_we_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_data    = wb_data_q;
  assign wb_we      = wb_we_q;
  assign wb_regaddr = wb_regaddr_q;
  assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: expected write-backs are queued when an
// instruction is presented and popped when the stage raises wb_we.
module tb_stage_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_out;
  logic [1:0]  wbi;
  logic        M;
  logic [3:0]  regaddr;
  logic [31:0] data_b;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [3:0]  wb_regaddr;
  logic        bus_error;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ra;
  } wb_t;

  wb_t sb[$];
  int  vectors = 0;
  int  errors  = 0;

  stage_mem #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .alu_out(alu_out), .wbi(wbi), .M(M),
    .regaddr(regaddr), .data_b(data_b), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_data(wb_data), .wb_we(wb_we),
    .wb_regaddr(wb_regaddr), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_out = '0; wbi = 2'b00; M = 1'b0; regaddr = '0; data_b = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Pops the oldest expected write-back and compares it to the stage outputs.
  task automatic pop_wb(input string name);
    wb_t e;
    vectors++;
    if (wb_we !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s wb_we: got %b with %0d queued, required 1 with an entry", name, wb_we, sb.size());
    end else begin
      e = sb.pop_front();
      if (wb_data !== e.data || wb_regaddr !== e.ra) begin
        errors++;
        $display("FAIL %s wb: got %h/%0d required %h/%0d", name, wb_data, wb_regaddr, e.data, e.ra);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    wbi = 2'b11;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
    tick(); tick();
    vectors++;
    if ({mem_req, mem_we, wb_we, bus_error} !== 4'b0 || wb_data !== 32'h0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b wbwe=%b err=%b wbd=%h addr=%h required all 0",
               mem_req, mem_we, wb_we, bus_error, wb_data, mem_addr);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_alu();
    alu_out = 32'h1234; wbi = 2'b01; regaddr = 4'd5;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b required 0", stall); end
    sb.push_back('{data: 32'h1234, ra: 4'd5});
    tick();
    idle_inputs();
    pop_wb("alu_wb");
    tick();
    vectors++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL alu_nop_we: got %b required 0", wb_we); end
  endtask

  task automatic test_load();
    alu_out = 32'h103; wbi = 2'b11; regaddr = 4'd7;
    #1;
    vectors++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_stall: got %b required 1", stall); end
    sb.push_back('{data: 32'hDEADBEEF, ra: 4'd7});
    tick();
    alu_out = 32'hFFFF; wbi = 2'b00; regaddr = 4'd1;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL load_req: req=%b we=%b addr=%h wbwe=%b required 1/0/00000100/0", mem_req, mem_we, mem_addr, wb_we);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_ack_stall: got %b required 0", stall); end
    tick();
    idle_inputs();
    vectors++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b required 0", mem_req); end
    pop_wb("load_wb");
    tick();
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    alu_out = 32'h20; data_b = 32'hCAFE; M = 1'b1; wbi = 2'b00; regaddr = 4'd3;
    #1;
    if (stall === 1'b1) stalls++;
    tick();
    for (int i = 0; i < 3; i++) begin
      alu_out = 32'h0; data_b = 32'h0; M = 1'b0;
      #1;
      if (stall === 1'b1) stalls++;
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE || mem_addr !== 32'h20 || wb_we !== 1'b0) begin
        errors++;
        $display("FAIL store_wait%0d: req=%b we=%b wdata=%h addr=%h wbwe=%b", i, mem_req, mem_we, mem_wdata, mem_addr, wb_we);
      end
      tick();
    end
    mem_ack = 1'b1;
    #1;
    if (stall === 1'b1) stalls++;
    vectors++;
    if (stalls !== 4) begin errors++; $display("FAIL store_stall_cycles: got %0d required 4", stalls); end
    tick();
    idle_inputs();
    vectors++;
    if (mem_req !== 1'b0 || wb_we !== 1'b0 || bus_error !== 1'b0 || wb_data !== 32'h20) begin
      errors++;
      $display("FAIL store_done: req=%b wbwe=%b err=%b wbd=%h required 0/0/0/00000020", mem_req, wb_we, bus_error, wb_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    alu_out = 32'h40; wbi = 2'b11; regaddr = 4'd9;
    tick();
    idle_inputs();
    for (int i = 0; i < 12 && mem_req === 1'b1; i++) begin
      req_cycles++;
      tick();
    end
    vectors++;
    if (req_cycles !== 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d required 4", req_cycles); end
    vectors++;
    if (bus_error !== 1'b1 || wb_we !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: err=%b wbwe=%b req=%b required 1/0/0", bus_error, wb_we, mem_req);
    end
    alu_out = 32'h55; wbi = 2'b01; regaddr = 4'd2;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL timeout_next_stall: got %b required 0", stall); end
    sb.push_back('{data: 32'h55, ra: 4'd2});
    tick();
    idle_inputs();
    pop_wb("timeout_next_wb");
    tick();
  endtask

  task automatic test_reset_mid_wait();
    alu_out = 32'h80; wbi = 2'b11; regaddr = 4'd6;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait_stall: got %b required 0", stall); end
    tick();
    vectors++;
    if ({mem_req, mem_we, wb_we, bus_error} !== 4'b0 || wb_data !== 32'h0 || wb_regaddr !== 4'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_state: req=%b we=%b wbwe=%b err=%b wbd=%h addr=%h required all 0",
               mem_req, mem_we, wb_we, bus_error, wb_data, mem_addr);
    end
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (wb_we !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_ack: wbwe=%b req=%b required 0/0", wb_we, mem_req);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    alu_out = 32'h200; wbi = 2'b11; regaddr = 4'd4;
    sb.push_back('{data: 32'h11112222, ra: 4'd4});
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL b2b_load_req: req=%b we=%b addr=%h required 1/0/00000200", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    alu_out = 32'h300; data_b = 32'h77; M = 1'b1; wbi = 2'b00; regaddr = 4'd0;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: req=%b stall=%b required 0/1", mem_req, stall);
    end
    pop_wb("b2b_load_wb");
    tick();
    idle_inputs();
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'h77) begin
      errors++;
      $display("FAIL b2b_store_req: req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || wb_we !== 1'b0 || wb_data !== 32'h300) begin
      errors++;
      $display("FAIL b2b_store_done: req=%b wbwe=%b wbd=%h required 0/0/00000300", mem_req, wb_we, wb_data);
    end
    vectors++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_empty: got %0d entries required 0", sb.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
